// File: rtl/mem_responder_if.sv
// Datapath-to-memory request/response bundle (MOV/MFC handshake).
// Latency: none, wires only.
// Backpressure: the requester holds En until MFC is seen.
interface mem_responder_if;
  logic        En;
  logic        RW;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [1:0]  WordSel;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Err;

  modport master (
    output En, RW, Address, DataIn, WordSel,
    input  DataOut, MFC, Err
  );

  modport slave (
    input  En, RW, Address, DataIn, WordSel,
    output DataOut, MFC, Err
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressable big-endian RAM answering the datapath MOV/MFC handshake.
// Latency: MFC rises WAIT_CYCLES+1 edges after En is first sampled.
// Backpressure: MFC holds while En is high; En low drops MFC. Macro ALIGN_CHECK_EN enables alignment faults.
module mem_responder #(
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_CYCLES = 2
) (
  input logic            Clk,
  input logic            Clr,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, nextState;
  logic [CW-1:0] waitCnt;
  logic          reqRW;
  logic [31:0]   reqAddr;
  logic [31:0]   reqData;
  logic [1:0]    reqSize;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [31:0]   dataOutReg;
  logic          mfcReg;
  logic          latchReq, doAccess, dropMfc, fault;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   readData;
  logic          unusedAddrBits;

  // Only the low address bits select a byte; the rest wrap away.
  assign unusedAddrBits = ^reqAddr[31:AW];

  // Byte lanes of the access, each wrapping independently modulo the RAM size.
  assign a0 = reqAddr[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

`ifdef ALIGN_CHECK_EN
  assign fault = ((reqSize == 2'b01) && reqAddr[0]) ||
                 ((reqSize == 2'b10) && (reqAddr[1:0] != 2'b00)) ||
                 (reqSize == 2'b11);
`else
  assign fault = 1'b0;
`endif

  // Right-aligned, zero-extended read data; reserved size reads a word.
  always_comb begin
    readData = {b0, b1, b2, b3};
    case (reqSize)
      2'b00:   readData = {24'd0, b0};
      2'b01:   readData = {16'd0, b0, b1};
      default: readData = {b0, b1, b2, b3};
    endcase
  end

  // Next-state and control strobes; the access fires on the first edge spent in DONE.
  always_comb begin
    nextState = state;
    latchReq  = 1'b0;
    doAccess  = 1'b0;
    dropMfc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.En) begin
          latchReq  = 1'b1;
          nextState = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (!bus.En)                  nextState = IDLE;
        else if (waitCnt == LAST_CNT) nextState = DONE;
      end
      DONE: begin
        if (!bus.En) begin
          nextState = IDLE;
          dropMfc   = 1'b1;
        end else if (!mfcReg) begin
          doAccess = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Clr) state <= IDLE;
    else     state <= nextState;
  end

  // Wait-state counter, only advancing while in WAIT.
  always_ff @(posedge Clk) begin
    if (Clr || state != WAIT || waitCnt == LAST_CNT) waitCnt <= '0;
    else                                             waitCnt <= waitCnt + CW'(1);
  end

  // Request capture; later changes on the inputs are ignored.
  always_ff @(posedge Clk) begin
    if (!Clr && latchReq) begin
      reqRW   <= bus.RW;
      reqAddr <= bus.Address;
      reqData <= bus.DataIn;
      reqSize <= bus.WordSel;
    end
  end

  // Completion outputs: MFC and read data load on the access edge.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      mfcReg     <= 1'b0;
      dataOutReg <= '0;
    end else if (doAccess) begin
      mfcReg <= 1'b1;
      if (reqRW && !fault) dataOutReg <= readData;
    end else if (dropMfc) begin
      mfcReg <= 1'b0;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic errReg;

  // Fault flag rises with MFC and clears with it.
  always_ff @(posedge Clk) begin
    if (Clr)           errReg <= 1'b0;
    else if (doAccess) errReg <= fault;
    else if (dropMfc)  errReg <= 1'b0;
  end

  assign bus.Err = errReg;
`else
  assign bus.Err = 1'b0;
`endif

  // RAM write port; contents survive Clr.
  always_ff @(posedge Clk) begin
    if (!Clr && doAccess && !reqRW && !fault) begin
      case (reqSize)
        2'b00: mem[a0] <= reqData[7:0];
        2'b01: begin
          mem[a0] <= reqData[15:8];
          mem[a1] <= reqData[7:0];
        end
        default: begin
          mem[a0] <= reqData[31:24];
          mem[a1] <= reqData[23:16];
          mem[a2] <= reqData[15:8];
          mem[a3] <= reqData[7:0];
        end
      endcase
    end
  end

  assign bus.DataOut = dataOutReg;
  assign bus.MFC     = mfcReg;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's RAM handshake: the datapath asserts an enable with address (from MAR), write data (from MDR), read/write and size; this block holds MFC (memory function complete) low, performs the access, then raises MFC.
- Byte-addressable RAM with configurable wait states and big-endian byte/halfword/word access. The datapath uses it as its instruction/data memory and waits on MFC before loading IR/MDR.

Parameters:
- DEPTH_BYTES, 512, RAM size in bytes; power of two; address taken modulo DEPTH_BYTES.
- WAIT_CYCLES, 2, extra wait states between request acceptance and MFC; 0 is legal.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Clr  input  1  reset, synchronous, active-high.
- En  input  1  request (MOV) from the datapath; must be held high until MFC is seen.
- RW  input  1  1 = read, 0 = write; sampled with En.
- Address  input  32  byte address (MAR).
- DataIn  input  32  write data (MDR); the right-aligned low bits are used for byte and halfword writes.
- WordSel  input  2  size: 00 byte, 01 halfword, 10 word, 11 reserved.
- DataOut  output  32  read data, zero-extended and right-aligned.
- MFC  output  1  access complete.
- Err  output  1  access fault; driven only when ALIGN_CHECK_EN is defined, otherwise tied 0.

Behaviour:
- Reset (Clr=1 at an edge):
  - state=IDLE, MFC=0, DataOut=0, Err=0, wait counter=0.
  - RAM contents are not cleared.
  - Clr has priority over all other inputs.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On En=1, latch RW, Address, DataIn and WordSel into request registers.
  - Go to WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - Counter counts from 0 to WAIT_CYCLES-1, then go to DONE.
  - If En=0 while in WAIT: abort, return to IDLE, no write performed, MFC stays 0.
- Entry into DONE (single edge):
  - Write: update RAM bytes.
  - Read: load DataOut.
  - Set MFC=1.
- DONE:
  - Hold MFC=1 and DataOut while En=1.
  - When En=0 at an edge: MFC=0, go to IDLE. DataOut keeps its last value.
  - A new request requires at least one IDLE cycle with En=0.
- Latency: if En is first sampled at edge k, MFC is high after edge k+1+WAIT_CYCLES. WAIT_CYCLES=0 gives MFC after edge k+1.
- Request inputs are ignored after latch; changes during WAIT or DONE have no effect.
- Byte order is big-endian. The word at address A is bytes A (bits 31:24), A+1, A+2, A+3 (bits 7:0).
- Halfword at A: byte A is bits 15:8, byte A+1 is bits 7:0, upper bits 0. Byte: bits 7:0, upper bits 0.
- Writes: byte writes DataIn[7:0]; halfword writes DataIn[15:0]; word writes all 32 bits. Bytes not covered by the size are unchanged.
- WordSel=11 is treated as word.
- Address wrap: effective address = Address mod DEPTH_BYTES. The bytes of a multi-byte access also wrap; for example, a word at DEPTH_BYTES-2 touches bytes DEPTH-2, DEPTH-1, 0, 1.
- Without ALIGN_CHECK_EN, misaligned halfword/word accesses are performed at the unaligned byte address as stated above. No forcing to alignment.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined, a request is a fault when any of these hold:
  - halfword with Address[0]=1;
  - word with Address[1:0]!=00;
  - WordSel=11.
- On a fault:
  - The normal wait-state latency applies.
  - On entry to DONE: no RAM write, DataOut unchanged, MFC=1, Err=1.
  - Err clears together with MFC.
- Undefined: Err is constant 0; no checking; behaviour as in Behaviour.

Test Plan:
- Word write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 and drop En after MFC; read 0x10 -> MFC exactly 3 edges after En, DataOut=0xDEADBEEF.
- Big-endian sizes, after the 0x10 write: byte read 0x10 -> 0x000000DE; byte read 0x13 -> 0x000000EF; halfword read 0x12 -> 0x0000BEEF. Then byte write 0x55 to 0x11 and word read 0x10 -> 0xDE55BEEF.
- Abort: a write of 0x12345678 to 0x20 with En dropped during WAIT -> MFC never rises; a later read of 0x20 returns the prior contents (0x00000000 after preload of zeros).
- Handshake hold: hold En 5 cycles after MFC -> MFC stays 1 and DataOut stays stable; MFC=0 one edge after En drops. Back-to-back requests with one idle cycle both complete.
- Reset mid-operation: Clr during WAIT of a write to 0x30 -> MFC=0, DataOut=0 next edge; RAM at 0x30 is unchanged; the previously written 0x10 data survives Clr.
- ALIGN_CHECK_EN defined: word write 0xAAAAAAAA to 0x21 -> MFC=1 with Err=1; RAM at 0x20..0x23 is unchanged; Err=0 after En drops. Undefined: the same access writes bytes 0x21..0x24 and Err stays 0.
